// File: rtl/player_sprite_fetch_if.sv
// Sprite ROM read bus: address and player select out, palette index back one clk later.
interface player_sprite_fetch_if;
  logic [9:0] rom_addr;
  logic       rom_player;
  logic [3:0] rom_data;

  modport master (
    output rom_addr,
    output rom_player,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    input  rom_player,
    output rom_data
  );
endinterface

// File: rtl/player_sprite_fetch.sv
// Player sprite address generation and pixel return, fixed 3-clk latency from draw coordinate to sprite_*.
// Optional horizontal mirroring per player is enabled by defining SPRITE_MIRROR_EN.
module player_sprite_fetch #(
  parameter int         SPRITE_W        = 30,
  parameter int         SPRITE_H        = 30,
  parameter logic [3:0] TRANSPARENT_IDX = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       pix_valid,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  input  logic [9:0] p1_x,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_x,
  input  logic [9:0] p2_y,
`ifdef SPRITE_MIRROR_EN
  input  logic       p1_face_left,
  input  logic       p2_face_left,
`endif
  player_sprite_fetch_if.master rom,
  output logic       sprite_on,
  output logic [3:0] sprite_idx,
  output logic       sprite_owner
);

  // Per-player arrays: index 1 = P1, index 0 = P2, matching rom_player encoding.
  logic [9:0] pos_x_in [2];
  logic [9:0] pos_y_in [2];
  logic [9:0] pos_x_reg [2];
  logic [9:0] pos_y_reg [2];
  logic [1:0] face_in;
  logic [1:0] face_reg;

  logic [1:0] hit;
  logic [9:0] addr [2];
  logic       any_hit;
  logic [9:0] rom_addr_next;

  logic [9:0] rom_addr_reg;
  logic       rom_player_reg;
  logic       s1_valid_reg;
  logic       s2_valid_reg;
  logic       s2_owner_reg;
  logic       opaque;

  assign pos_x_in[1] = p1_x;
  assign pos_y_in[1] = p1_y;
  assign pos_x_in[0] = p2_x;
  assign pos_y_in[0] = p2_y;

`ifdef SPRITE_MIRROR_EN
  assign face_in = {p1_face_left, p2_face_left};
`else
  assign face_in = 2'b00;
`endif

  function automatic logic [9:0] lin_addr(input logic [9:0] row, input logic [9:0] col);
    if (SPRITE_W == 30)
      lin_addr = (row << 5) - (row << 1) + col;
    else
      lin_addr = 10'(row * 10'(SPRITE_W)) + col;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_player
      logic [9:0]  px;
      logic [9:0]  py;
      logic        face;
      logic [10:0] dx;
      logic [10:0] dy;
      logic [9:0]  col;

      // Same-cycle frame_start bypasses the latch so the new positions apply immediately.
      assign px   = frame_start ? pos_x_in[gi] : pos_x_reg[gi];
      assign py   = frame_start ? pos_y_in[gi] : pos_y_reg[gi];
      assign face = frame_start ? face_in[gi]  : face_reg[gi];
      assign dx   = {1'b0, draw_x} - {1'b0, px};
      assign dy   = {1'b0, draw_y} - {1'b0, py};

      assign hit[gi] = pix_valid
                     && !dx[10] && (dx[9:0] <= 10'(SPRITE_W - 1))
                     && !dy[10] && (dy[9:0] <= 10'(SPRITE_H - 1));
      assign col      = face ? (10'(SPRITE_W - 1) - dx[9:0]) : dx[9:0];
      assign addr[gi] = lin_addr(dy[9:0], col);
    end
  endgenerate

  assign any_hit       = |hit;
  assign rom_addr_next = hit[1] ? addr[1] : addr[0];
  assign opaque        = s2_valid_reg && (rom.rom_data != TRANSPARENT_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        pos_x_reg[i] <= '0;
        pos_y_reg[i] <= '0;
      end
      face_reg       <= '0;
      rom_addr_reg   <= '0;
      rom_player_reg <= 1'b0;
      s1_valid_reg   <= 1'b0;
      s2_valid_reg   <= 1'b0;
      s2_owner_reg   <= 1'b0;
      sprite_on      <= 1'b0;
      sprite_idx     <= '0;
      sprite_owner   <= 1'b0;
    end else begin
      if (frame_start) begin
        for (int i = 0; i < 2; i++) begin
          pos_x_reg[i] <= pos_x_in[i];
          pos_y_reg[i] <= pos_y_in[i];
        end
        face_reg <= face_in;
      end
      // Address and select hold on a miss; only the valid bit says the read is meaningful.
      if (any_hit) begin
        rom_addr_reg   <= rom_addr_next;
        rom_player_reg <= hit[1];
      end
      s1_valid_reg <= any_hit;
      s2_valid_reg <= s1_valid_reg;
      s2_owner_reg <= rom_player_reg;
      sprite_on    <= opaque;
      sprite_idx   <= opaque ? rom.rom_data : 4'h0;
      sprite_owner <= opaque ? s2_owner_reg : 1'b0;
    end
  end

  assign rom.rom_addr   = rom_addr_reg;
  assign rom.rom_player = rom_player_reg;

endmodule

// File: doc/player_sprite_fetch.md
Name: player_sprite_fetch

Overview:
- Address-generation and pixel-return stage in front of the player sprite ROM (30x30 sprites, 4-bit palette index, 1-cycle registered read, player select 1 = P1, 0 = P2).
- Takes the VGA draw coordinate and both players' positions, and decides which player's sprite covers the pixel.
- Drives the ROM address and player select, then consumes the returned index.
- Emits a pipelined sprite_on / palette index / owner to the colour mapper.

Parameters:
- SPRITE_W, 30, sprite width in pixels
- SPRITE_H, 30, sprite height in pixels
- TRANSPARENT_IDX, 4'h0, palette index treated as see-through

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- frame_start  in  1  one-cycle pulse at the start of each frame; latches player positions
- pix_valid  in  1  draw_x/draw_y are inside the visible area this cycle
- draw_x  in  10  current pixel column
- draw_y  in  10  current pixel row
- p1_x, p1_y  in  10 each  P1 sprite top-left corner
- p2_x, p2_y  in  10 each  P2 sprite top-left corner
- rom_addr  out  10  sprite ROM read address
- rom_player  out  1  sprite ROM player select (1 = P1, 0 = P2)
- rom_data  in  4  sprite ROM data, valid one clk after rom_addr/rom_player
- sprite_on  out  1  opaque player pixel at the output coordinate
- sprite_idx  out  4  palette index; 0 when sprite_on = 0
- sprite_owner  out  1  1 = P1, 0 = P2; 0 when sprite_on = 0

Behaviour:
- Reset (rst_n = 0 at a clk edge) clears:
  - all outputs: rom_addr = 0, rom_player = 0, sprite_on = 0, sprite_idx = 0, sprite_owner = 0;
  - the latched positions (all 0);
  - the pipeline valid bits.
- Reset mid-frame: outputs stay 0 until the first pixel that enters after reset has traversed the pipe. The latched positions stay 0 until the next frame_start.
- Position latch:
  - On frame_start, p1_x/p1_y/p2_x/p2_y are registered and held for the whole frame, so sprites do not tear.
  - A pixel presented in the same cycle as frame_start uses the incoming (new) positions through a bypass.
- Stage 0, combinational, registered into stage 1:
  - dx = draw_x - px and dy = draw_y - py, computed 11-bit signed.
  - Hit when 0 <= dx <= SPRITE_W-1, 0 <= dy <= SPRITE_H-1, and pix_valid = 1.
  - No wrap: a sprite at x = 630 covers columns 630..639 only. Columns 640+ are never presented.
- Priority: if both players hit, P1 wins (rom_player = 1).
  - No second read is issued, so a transparent P1 pixel over P2 shows neither sprite.
- Address: rom_addr = dy*SPRITE_W + dx. With the default width this is (dy<<5) - (dy<<1) + dx, with no multiplier. The maximum is 899.
- No hit: rom_addr holds its previous value, and the stage-1 valid bit is cleared.
- Stage 1: rom_addr/rom_player are registered at edge k+1 for a coordinate presented before edge k+1. The owner and valid bits travel alongside.
- Stage 2: the ROM returns rom_data after edge k+2.
- Stage 3: at edge k+3:
  - sprite_on = valid & (rom_data != TRANSPARENT_IDX);
  - sprite_idx = rom_data if sprite_on, else 0;
  - sprite_owner = owner if sprite_on, else 0.
- Latency: fixed 3 clk from draw_x/draw_y to sprite_*. The pipe is fully pipelined at one pixel per clk with no stalls. The colour mapper delays its coordinate by 3.

Optional Feature:
- Macro: SPRITE_MIRROR_EN.
- Defined:
  - Adds inputs p1_face_left and p2_face_left (1 bit each), latched on frame_start together with the positions.
  - When the owning player's bit is 1, the column term becomes SPRITE_W-1-dx, flipping the sprite horizontally.
  - Latency is unchanged.
- Undefined: the ports are absent and the column term is always dx.

Test Plan:
1. Reset: hold rst_n = 0 for 4 clk with pix_valid = 1 over a sprite -> all outputs 0; after release, the first sprite_on appears no earlier than 3 clk after the first valid coordinate.
2. P1 at (100,50), frame_start; draw (100,50), (129,79), (130,50) -> rom_addr 0, 899, no hit; rom_player = 1 on the first two; sprite_* 3 clk later.
3. P1 and P2 both at (200,200); draw (205,203) -> rom_player = 1, rom_addr = 95; ROM returns 4'h7 -> sprite_on = 1, idx = 7, owner = 1.
4. Transparency: P2 only at (10,10); ROM returns 4'h0 at (12,10) -> sprite_on = 0, idx = 0, owner = 0; returns 4'h3 at the next pixel -> sprite_on = 1, owner = 0.
5. Move p1_x from 100 to 300 mid-frame without frame_start -> hits still use x = 100; after frame_start the coordinate (300,50) gives rom_addr 0.
6. SPRITE_MIRROR_EN, p1_face_left = 1, P1 at (0,0); draw (0,0) -> rom_addr 29; draw (29,1) -> rom_addr 30.
